// File: rtl/pc_irq_scheduler.sv
// pc_irq_scheduler
//   Interrupt-stimulus sequencer for the pipelined MIPS core. Watches the
//   core's PC (addr). When addr matches the programmed trigger PC, it waits a
//   programmed delay and then holds irq high for a programmed width. This
//   repeats for a programmed number of shots. After each shot the PC has to
//   leave the trigger address before the next shot can fire.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   cfg_we       load cfg_* and (re)arm; overrides abort and normal sequencing
//   cfg_trig_pc  trigger PC
//   cfg_delay    cycles from the sampled match to the first irq cycle
//   cfg_width    irq is high for cfg_width+1 cycles
//   cfg_shots    number of shots; 0 loads the config but leaves the block idle
//   abort        cancel all activity and return to idle
//   addr         macroscopic PC from the core
//   irq          registered interrupt request to the core
//   busy         high while armed, delaying or asserting
//   fire         one-cycle pulse on the first irq cycle of each shot
//   fire_cnt     shots fired since reset; saturates at all-ones
module pc_irq_scheduler #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_trig_pc,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_shots,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr,
  output logic              irq,
  output logic              busy,
  output logic              fire,
  output logic [CNT_W-1:0]  fire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_ASSERT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] trig_pc;
  logic [CNT_W-1:0]  delay_r;
  logic [CNT_W-1:0]  width_r;
  logic [CNT_W-1:0]  shots_left;
  logic [CNT_W-1:0]  dcnt;
  logic [CNT_W-1:0]  wcnt;
  logic              seen_leave;
  logic              match;
  logic              to_assert;
  logic              to_delay;
  logic              shot_done;

  assign match = (addr == trig_pc);
  assign busy  = (state == S_ARMED) || (state == S_DELAY) || (state == S_ASSERT);

  // cfg_we and abort are folded into next-state so the sequencing strobes
  // (to_assert, to_delay, shot_done) only fire when neither overrides.
  always_comb begin
    state_next = state;
    to_assert  = 1'b0;
    to_delay   = 1'b0;
    shot_done  = 1'b0;
    if (cfg_we) begin
      state_next = (cfg_shots != '0) ? S_ARMED : S_IDLE;
    end else if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_ARMED: begin
          if (match && seen_leave) begin
            if (delay_r == '0) begin
              state_next = S_ASSERT;
              to_assert  = 1'b1;
            end else begin
              state_next = S_DELAY;
              to_delay   = 1'b1;
            end
          end
        end
        S_DELAY: begin
          if (dcnt == '0) begin
            state_next = S_ASSERT;
            to_assert  = 1'b1;
          end
        end
        S_ASSERT: begin
          if (wcnt == '0) begin
            shot_done  = 1'b1;
            state_next = (shots_left != CNT_W'(1)) ? S_ARMED : S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq      <= 1'b0;
      fire     <= 1'b0;
      fire_cnt <= '0;
    end else begin
      irq  <= (state_next == S_ASSERT);
      fire <= to_assert;
      if (to_assert && (fire_cnt != '1)) fire_cnt <= fire_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_pc    <= '0;
      delay_r    <= '0;
      width_r    <= '0;
      shots_left <= '0;
      dcnt       <= '0;
      wcnt       <= '0;
      seen_leave <= 1'b1;
    end else if (cfg_we) begin
      trig_pc    <= cfg_trig_pc;
      delay_r    <= cfg_delay;
      width_r    <= cfg_width;
      shots_left <= cfg_shots;
      seen_leave <= 1'b1;
    end else if (abort) begin
      shots_left <= '0;
    end else begin
      // Finishing a shot forces the PC to leave the trigger again, even if it
      // already differs in that same cycle.
      if (shot_done)   seen_leave <= 1'b0;
      else if (!match) seen_leave <= 1'b1;

      if (to_delay)              dcnt <= delay_r - CNT_W'(1);
      else if (state == S_DELAY) dcnt <= dcnt - CNT_W'(1);

      if (to_assert)             wcnt <= width_r;
      else if (state == S_ASSERT && wcnt != '0) wcnt <= wcnt - CNT_W'(1);

      if (shot_done) shots_left <= shots_left - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_irq_scheduler.sv
module tb_pc_irq_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_trig_pc = '0;
  logic [7:0]  cfg_delay = '0;
  logic [7:0]  cfg_width = '0;
  logic [7:0]  cfg_shots = '0;
  logic        abort = 1'b0;
  logic [31:0] addr = '0;
  logic        irq, busy, fire;
  logic [7:0]  fire_cnt;

  pc_irq_scheduler #(.ADDR_W(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_trig_pc(cfg_trig_pc),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_shots(cfg_shots),
    .abort(abort), .addr(addr), .irq(irq), .busy(busy), .fire(fire),
    .fire_cnt(fire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       irq;
    logic       busy;
    logic       fire;
    logic [7:0] fc;
    longint     cyc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model: a shot is a time window [m_on, m_off] of edge numbers.
  // mode: 0 idle, 1 armed, 2 shot scheduled/in progress, 3 done.
  int          m_mode = 0;
  longint      m_on = 0, m_off = 0;
  logic [31:0] m_trig = '0;
  int          m_delay = 0, m_width = 0, m_shots = 0, m_fc = 0;
  bit          m_seen = 1'b1;
  longint      n = 1;

  task automatic model_edge();
    exp_t e;
    bit   hit, ended;
    hit = 1'b0;
    ended = 1'b0;
    if (reset) begin
      m_mode = 0; m_trig = '0; m_delay = 0; m_width = 0; m_shots = 0;
      m_seen = 1'b1; m_fc = 0;
    end else if (cfg_we) begin
      m_trig = cfg_trig_pc; m_delay = int'(cfg_delay); m_width = int'(cfg_width);
      m_shots = int'(cfg_shots); m_seen = 1'b1;
      m_mode = (m_shots != 0) ? 1 : 0;
    end else if (abort) begin
      m_mode = 0; m_shots = 0;
    end else begin
      hit = (addr == m_trig);
      if (m_mode == 2 && n == m_off + 1) begin
        ended = 1'b1;
        m_shots = m_shots - 1;
        m_mode = (m_shots != 0) ? 1 : 3;
      end else if (m_mode == 1 && hit && m_seen) begin
        m_on = n + m_delay;
        m_off = m_on + m_width;
        m_mode = 2;
      end
      if (ended) m_seen = 1'b0;
      else if (!hit) m_seen = 1'b1;
      if (m_mode == 2 && n == m_on && m_fc < 255) m_fc = m_fc + 1;
    end
    e.irq  = (m_mode == 2 && n >= m_on && n <= m_off);
    e.fire = (m_mode == 2 && n == m_on);
    e.busy = (m_mode == 1 || m_mode == 2);
    e.fc   = 8'(m_fc);
    e.cyc  = n;
    q.push_back(e);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #2;
    n = n + 1;
  endtask

  task automatic load(input logic [31:0] pc, input int d, input int w, input int s);
    cfg_we = 1'b1; cfg_trig_pc = pc;
    cfg_delay = 8'(d); cfg_width = 8'(w); cfg_shots = 8'(s);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic hold(input logic [31:0] a, input int cycles);
    addr = a;
    repeat (cycles) step();
  endtask

  task automatic chk(input string name, input longint cyc, input longint act, input longint req);
    n_total = n_total + 1;
    if (act == req) n_pass = n_pass + 1;
    else $display("FAIL %s edge %0d: got %0d, expected %0d", name, cyc, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("irq", e.cyc, longint'(irq), longint'(e.irq));
        chk("busy", e.cyc, longint'(busy), longint'(e.busy));
        chk("fire", e.cyc, longint'(fire), longint'(e.fire));
        chk("fire_cnt", e.cyc, longint'(fire_cnt), longint'(e.fc));
      end
    end
  end

  initial begin : stim
    logic [31:0] pcs [3];
    pcs[0] = 32'h3010; pcs[1] = 32'h3014; pcs[2] = 32'h4198;
    #1;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    hold(32'h0, 2);

    // delay 0, width 5, single shot
    load(32'h3010, 0, 5, 1);
    hold(32'h3010, 1);
    hold(32'h0, 8);

    // delay 3, width 0; addr wiggles during the delay
    load(32'h3010, 3, 0, 1);
    hold(32'h3010, 1);
    hold(32'h3014, 1);
    hold(32'h3010, 1);
    hold(32'h3014, 1);
    hold(32'h0, 4);

    // stalled PC fires once, then re-trigger after leaving
    load(32'h3010, 0, 0, 2);
    hold(32'h3010, 20);
    hold(32'h3014, 1);
    hold(32'h3010, 3);
    hold(32'h0, 2);

    // abort on the third irq cycle
    load(32'h3010, 0, 5, 1);
    hold(32'h3010, 1);
    hold(32'h0, 2);
    abort = 1'b1; step(); abort = 1'b0;
    hold(32'h3014, 1);
    hold(32'h3010, 3);

    // reconfigure during assert
    load(32'h3010, 0, 5, 1);
    hold(32'h3010, 1);
    hold(32'h0, 1);
    addr = 32'h3010;
    load(32'h4198, 0, 2, 1);
    hold(32'h3010, 3);
    hold(32'h4198, 5);

    // reset during delay and during assert
    load(32'h3010, 2, 3, 2);
    hold(32'h3010, 1);
    reset = 1'b1; step(); reset = 1'b0;
    hold(32'h3010, 3);
    load(32'h3010, 2, 3, 2);
    hold(32'h3010, 1);
    hold(32'h0, 3);
    reset = 1'b1; step(); reset = 1'b0;
    hold(32'h3014, 1);
    hold(32'h3010, 3);

    // maximum width: 256 irq cycles
    load(32'h3010, 0, 255, 1);
    hold(32'h3010, 1);
    hold(32'h0, 260);

    // drive fire_cnt into saturation
    load(32'h3010, 0, 0, 255);
    repeat (260) begin
      hold(32'h3010, 1);
      hold(32'h3014, 2);
    end
    load(32'h3010, 0, 0, 5);
    repeat (6) begin
      hold(32'h3010, 1);
      hold(32'h3014, 2);
    end

    // randomized traffic
    reset = 1'b1; step(); reset = 1'b0;
    repeat (2000) begin
      reset  = ($urandom_range(0, 199) == 0);
      cfg_we = !reset && ($urandom_range(0, 29) == 0);
      if (cfg_we) begin
        cfg_trig_pc = pcs[$urandom_range(0, 2)];
        cfg_delay   = 8'($urandom_range(0, 4));
        cfg_width   = 8'($urandom_range(0, 4));
        cfg_shots   = 8'($urandom_range(0, 3));
      end
      abort = ($urandom_range(0, 79) == 0);
      addr  = pcs[$urandom_range(0, 2)];
      step();
    end
    reset = 1'b0; cfg_we = 1'b0; abort = 1'b0;
    hold(32'h0, 3);

    if (q.size() != 0) begin
      n_total = n_total + 1;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
